// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port memory transfer controller.
// Accepts a write or read request in IDLE, then streams beats to or from a
// synchronous memory with read latency RD_LAT (1..4). Reads are issued
// back-to-back and a valid pipeline tracks returning data until it drains.
// Build option: define MEM_ACCESS_BURST_EN to honour len (1..16 beats);
// without it every transfer is exactly one beat and len is ignored.
// Handshake: wdata is taken in every cycle where wdata_ack=1 (no backpressure);
// rdata is meaningful only in cycles where rdata_valid=1; req is looked at only
// while busy=0 and is dropped, not queued, otherwise.
module mem_access_ctrl #(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    len,
  input  logic [DW-1:0] wdata,
  output logic          wdata_ack,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          busy,
  output logic          done,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [AW-1:0]       cur_addr;
  logic                last_beat;
  logic [RD_LAT-1:0]   rd_pipe;
  logic                drain_end;
  logic                start;
  logic                active;

  assign start     = (state == S_IDLE) && req;
  assign active    = (state == S_WRITE) || (state == S_READ);
  // Last outstanding read beat is being presented and nothing is left in flight.
  assign drain_end = (state == S_DRAIN) && rdata_valid && (rd_pipe == '0);
  assign dbg_state = state;

`ifdef MEM_ACCESS_BURST_EN
  logic [3:0] beats;

  // Remaining-beat counter: loaded from len, counts down once per issued beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats <= 4'd0;
    end else if (start) begin
      beats <= len;
    end else if (active) begin
      beats <= beats - 4'd1;
    end
  end

  assign last_beat = (beats == 4'd0);
`else
  logic unused_len;
  assign unused_len = ^len;
  assign last_beat  = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Current beat address; wraps naturally modulo 2^AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
    end else if (start) begin
      cur_addr <= addr;
    end else if (active) begin
      cur_addr <= cur_addr + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req) state_nx = we ? S_WRITE : S_READ;
      S_WRITE: if (last_beat) state_nx = S_DONE;
      S_READ:  if (last_beat) state_nx = S_DRAIN;
      S_DRAIN: if (drain_end) state_nx = S_IDLE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Memory strobes, write handshake and status outputs decoded from state.
  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    wdata_ack = 1'b0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE) || drain_end;
    case (state)
      S_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = cur_addr;
        mem_din   = wdata;
        wdata_ack = 1'b1;
      end
      S_READ: begin
        mem_read = 1'b1;
        mem_addr = cur_addr;
      end
      default: begin
        mem_write = 1'b0;
      end
    endcase
  end

  // Read-valid pipeline: bit i set means a read issued i+1 cycles ago is in
  // flight; the top bit marks the cycle in which mem_dout carries its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe     <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      rd_pipe     <= rd_pipe << 1;
      rd_pipe[0]  <= mem_read;
      rdata_valid <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) begin
        rdata <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl with a 512x16 behavioural memory (RD_LAT=1).
// Expected beats are derived from the stimulus and pushed into queues; a
// negedge monitor pops and compares whenever the DUT strobes or returns data.
module tb_mem_access_ctrl;
  localparam int AW = 9;
  localparam int DW = 16;
`ifdef MEM_ACCESS_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [3:0]    len;
  logic [DW-1:0] wdata;
  logic          wdata_ack;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          busy;
  logic          done;
  logic          mem_write;
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [2:0]    dbg_state;

  mem_access_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .len(len),
    .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_din;
    if (mem_read)  mem_dout <= mem[mem_addr];
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int exp_done  = 0;
  int done_seen = 0;
  bit mon_en    = 1'b0;
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [AW-1:0]    exp_ra_q[$];
  logic [DW-1:0]    exp_rd_q[$];
  logic [DW-1:0]    wq[$];
  logic [DW-1:0]    exp_mem [512];
  logic [DW-1:0]    wbuf [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbeats(input logic [3:0] l);
    return BURST ? int'(l) + 1 : 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_exp(input bit w, input logic [AW-1:0] a, input logic [3:0] l);
    logic [AW-1:0] ak;
    for (int k = 0; k < nbeats(l); k++) begin
      ak = a + k[AW-1:0];
      if (w) begin
        wq.push_back(wbuf[k]);
        exp_wr_q.push_back({ak, wbuf[k]});
        exp_mem[ak] = wbuf[k];
      end else begin
        exp_ra_q.push_back(ak);
        exp_rd_q.push_back(exp_mem[ak]);
      end
    end
    exp_done++;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after req.
  task automatic send_req(input bit w, input logic [AW-1:0] a, input logic [3:0] l);
    req = 1'b1; we = w; addr = a; len = l;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = ~a; len = ~l;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 0);
  endtask

  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [3:0] l);
    push_exp(w, a, l);
    send_req(w, a, l);
    wait_idle();
  endtask

  // Write data source: presents the head of wq, advances after each acked beat.
  initial begin
    bit ack_seen;
    wdata = '0;
    forever begin
      @(negedge clk);
      ack_seen = wdata_ack;
      @(posedge clk); #1;
      if (ack_seen && wq.size() > 0) void'(wq.pop_front());
      wdata = (wq.size() > 0) ? wq[0] : '0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [AW+DW-1:0] ew;
    if (mon_en) begin
      if (mem_write && mem_read) chk("both_strobes", 1, 0);
      chk("wdata_ack_vs_write", {31'b0, wdata_ack}, {31'b0, mem_write});
      if (mem_write) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", {31'b0, mem_write}, 0);
        else begin
          ew = exp_wr_q.pop_front();
          chk("wr_addr_data", {7'b0, mem_addr, mem_din}, {7'b0, ew});
        end
      end
      if (mem_read) begin
        if (exp_ra_q.size() == 0) chk("rd_unexpected", {31'b0, mem_read}, 0);
        else chk("rd_addr", {23'b0, mem_addr}, {23'b0, exp_ra_q.pop_front()});
      end
      if (rdata_valid) begin
        if (exp_rd_q.size() == 0) chk("rdata_unexpected", {31'b0, rdata_valid}, 0);
        else chk("rdata", {16'b0, rdata}, {16'b0, exp_rd_q.pop_front()});
      end
      if (done) done_seen++;
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flags"}, {26'b0, busy, done, wdata_ack, rdata_valid, mem_write, mem_read}, 0);
    chk({nm, "_rdata"}, {16'b0, rdata}, 0);
    chk({nm, "_mem_addr"}, {23'b0, mem_addr}, 0);
    chk({nm, "_mem_din"}, {16'b0, mem_din}, 0);
    chk({nm, "_state"}, {29'b0, dbg_state}, 0);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int cnt;
    int k_abort;
    for (int i = 0; i < 512; i++) exp_mem[i] = '0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    mon_en = 1'b1;
    rst = 1'b0;

    // Single write 0xABCD at 0: mem_write in cycle 1, done in cycle 2, idle in cycle 3.
    wbuf[0] = 16'hABCD;
    push_exp(1'b1, 9'd0, 4'd0);
    send_req(1'b1, 9'd0, 4'd0);
    @(negedge clk); chk("wr1_strobe_c1", {31'b0, mem_write}, 1);
    @(negedge clk); chk("wr1_done_c2", {30'b0, done, busy}, 2'b11);
    @(negedge clk); chk("wr1_idle_c3", {31'b0, busy}, 0);
    @(posedge clk); #1;

    // Single read at 0: mem_read in cycle 1, data with done in cycle 3.
    push_exp(1'b0, 9'd0, 4'd0);
    send_req(1'b0, 9'd0, 4'd0);
    @(negedge clk); chk("rd1_strobe_c1", {31'b0, mem_read}, 1);
    @(negedge clk); chk("rd1_gap_c2", {30'b0, rdata_valid, done}, 0);
    @(negedge clk); chk("rd1_valid_done_c3", {30'b0, rdata_valid, done}, 2'b11);
    @(posedge clk); #1;
    wait_idle();

    // Burst write/read of 10 beats, data = beat index.
    for (int k = 0; k < 16; k++) wbuf[k] = DW'(k);
    xfer(1'b1, 9'd0, 4'd9);
    xfer(1'b0, 9'd0, 4'd9);

    // Address wrap 511 -> 0.
    wbuf[0] = 16'h1234; wbuf[1] = 16'h5678;
    xfer(1'b1, 9'd511, 4'd1);
    xfer(1'b0, 9'd511, 4'd1);
    xfer(1'b0, 9'd0, 4'd0);

    // req with addr 100 pulsed while a 4-beat write is running must be ignored.
    for (int k = 0; k < 16; k++) wbuf[k] = 16'hC000 + DW'(k);
    push_exp(1'b1, 9'd40, 4'd3);
    send_req(1'b1, 9'd40, 4'd3);
    req = 1'b1; we = 1'b1; addr = 9'd100; len = 4'd0;
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle();

    // Reset during an 8-beat read at 0, right after the 3rd issue (1st without bursts).
    k_abort = BURST ? 3 : 1;
    for (int k = 0; k < (BURST ? 4 : 1); k++) exp_ra_q.push_back(AW'(k));
    for (int k = 0; k < (BURST ? 2 : 0); k++) exp_rd_q.push_back(exp_mem[k]);
    send_req(1'b0, 9'd0, 4'd7);
    cnt = 0;
    for (int c = 0; c < 50 && cnt < k_abort; c++) begin
      @(negedge clk);
      if (mem_read) cnt++;
    end
    chk("abort_reads_seen", cnt, k_abort);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("abort");
    rst = 1'b0;

    // First request straight after reset release works normally.
    xfer(1'b0, 9'd40, 4'd0);
    repeat (6) @(posedge clk);
    #1;

    chk("wr_q_left", exp_wr_q.size(), 0);
    chk("ra_q_left", exp_ra_q.size(), 0);
    chk("rd_q_left", exp_rd_q.size(), 0);
    chk("done_count", done_seen, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter AW, default 9, memory address width.
REQ-002 Parameter DW, default 16, data width.
REQ-003 Parameter RD_LAT, default 1, memory read latency in cycles (1..4).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  1  transfer request; sampled only in IDLE.
REQ-007 we  input  1  1 = write transfer, 0 = read transfer; latched with req.
REQ-008 addr  input  AW  start address; latched with req.
REQ-009 len  input  4  beats minus one (0 = 1 beat, 15 = 16 beats); latched with req.
REQ-010 wdata  input  DW  write data for the current beat.
REQ-011 wdata_ack  output  1  current wdata consumed this cycle.
REQ-012 rdata  output  DW  read data, registered.
REQ-013 rdata_valid  output  1  rdata holds one beat this cycle.
REQ-014 busy  output  1  transfer in progress; req ignored.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 mem_write / mem_read  output  1 each  memory strobes; never both 1.
REQ-017 mem_addr  output  AW  memory address.
REQ-018 mem_din  output  DW  memory write data.
REQ-019 mem_dout  input  DW  memory read data, valid RD_LAT cycles after mem_read.

Function
REQ-020 States: IDLE, WRITE, READ, DRAIN, DONE; busy=0 only in IDLE.
REQ-021 IDLE with req=1: latch we/addr/len, cur_addr=addr, beats=len; next WRITE if we=1, else READ.
REQ-022 WRITE: each cycle mem_write=1, mem_addr=cur_addr, mem_din=wdata, wdata_ack=1; cur_addr+1, beats-1; after last beat -> DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE; single write: req cycle 0, mem_write cycle 1, done cycle 2, new req accepted cycle 3.
REQ-024 READ: one mem_read per cycle at cur_addr, back-to-back, no gaps; after last issue -> DRAIN.
REQ-025 Read issued in cycle t: controller registers mem_dout at end of cycle t+RD_LAT; rdata_valid=1 with that data in cycle t+RD_LAT+1; beats return in issue order.
REQ-026 DRAIN: hold until all outstanding beats returned; done=1 in the same cycle as the last rdata_valid, then IDLE (no DONE state for reads).
REQ-027 Address arithmetic modulo 2^AW: 511+1 wraps to 0.
REQ-028 req while busy=1 ignored, not queued; we/addr/len changes while busy have no effect.
REQ-029 Outside WRITE/READ: mem_write=mem_read=0, mem_addr=0, mem_din=0; wdata_ack=0 outside WRITE.

Reset
REQ-030 rst=1 at a clock edge: state IDLE; busy, done, wdata_ack, rdata_valid, mem_write, mem_read =0; rdata, mem_addr, mem_din =0; beat counter and read-valid pipeline cleared.
REQ-031 Reset mid-transfer aborts it: no further strobes, no rdata_valid for in-flight reads, no done pulse.
REQ-032 First req accepted the cycle after rst deasserts.

Configuration
REQ-033 Macro MEM_ACCESS_BURST_EN defined: len honored, 1..16 beats per transfer.
REQ-034 MEM_ACCESS_BURST_EN undefined: len ignored, every transfer exactly one beat; beat counter logic absent; interface unchanged.

Verification (behavioural 512x16 memory model, RD_LAT=1, burst enabled unless noted)
REQ-035 Single write addr 0, wdata 0xABCD -> one mem_write cycle, mem_addr 0, mem_din 0xABCD, done cycle 2; then read addr 0 -> single rdata_valid, rdata 0xABCD, done with it.
REQ-036 Burst write addr 0, len 9, wdata = beat index -> 10 consecutive mem_write at addr 0..9 with 10 wdata_ack; burst read addr 0, len 9 -> 10 consecutive rdata_valid, data 0x0000..0x0009, done on the 10th.
REQ-037 Burst write addr 511, len 1, data 0x1234, 0x5678 -> mem_addr 511 then 0; reads of 511 and 0 return 0x1234 and 0x5678.
REQ-038 req pulsed with addr 100 during a 4-beat write -> no access to addr 100; exactly 4 mem_write cycles, one done.
REQ-039 rst asserted after 3rd mem_read of 8-beat read -> next cycle all outputs 0, no later rdata_valid or done; subsequent single read works normally.
REQ-040 MEM_ACCESS_BURST_EN undefined, write len 5 -> exactly one mem_write cycle, then done.
